// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART char transmitter.
// The lock is held per message; it is released on the last byte or on timeout.
module uart_tx_arbiter #(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 4800,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_data,
  input  logic [N_REQ-1:0]   i_last,
  output logic [N_REQ-1:0]   o_ack,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_char,
  input  logic               i_tx_busy,
  input  logic               i_tx_done,
  output logic               o_grant_valid,
  output logic [ID_W-1:0]    o_grant_id,
  output logic               o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_e;

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_REQ - 1);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              gv_q, gv_d;
  logic              last_q, last_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              start_q, start_d;
  logic [7:0]        char_q, char_d;
  logic              tmo_q, tmo_d;

  logic [ID_W-1:0]   win;
  logic              any_req;
  logic              req_id;
  logic              start_ok;
  logic              to_hit;

  // Round-robin pick: nearest set request after ptr, with wrap.
  always_comb begin
    win     = ptr_q;
    any_req = |i_req;
    for (int i = N_REQ; i >= 1; i--) begin
      if (i_req[(int'(ptr_q) + i) % N_REQ]) begin
        win = ID_W'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  // Holder-side conditions used by both FSM processes.
  always_comb begin
    req_id   = i_req[id_q];
    start_ok = req_id && !i_tx_busy;
    to_hit   = (TIMEOUT != 0) && !req_id &&
               (cnt_q == TO_LIM);
  end

  // State and registered-output storage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_RST;
      id_q    <= '0;
      gv_q    <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      char_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gv_q    <= gv_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      char_q  <= char_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state: grant, send byte, wait for frame end.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) state_d = S_SEND;
      end
      S_SEND: begin
        if (start_ok)    state_d = S_WAIT;
        else if (to_hit) state_d = S_IDLE;
      end
      S_WAIT: begin
        if (i_tx_done) begin
          state_d = last_q ? S_IDLE : S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; pulses default low.
  always_comb begin
    ptr_d   = ptr_q;
    id_d    = id_q;
    gv_d    = gv_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    start_d = 1'b0;
    char_d  = char_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          id_d  = win;
          gv_d  = 1'b1;
          cnt_d = '0;
        end
      end
      S_SEND: begin
        if (start_ok) begin
          start_d     = 1'b1;
          char_d      = i_data[8*id_q +: 8];
          ack_d[id_q] = 1'b1;
          last_d      = i_last[id_q];
          cnt_d       = '0;
        end else if (to_hit) begin
          tmo_d = 1'b1;
          gv_d  = 1'b0;
          ptr_d = id_q;
        end else if (!req_id && cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        if (i_tx_done && last_q) begin
          gv_d  = 1'b0;
          ptr_d = id_q;
        end
      end
      default: begin
        gv_d = 1'b0;
      end
    endcase
  end

  assign o_ack         = ack_q;
  assign o_tx_start    = start_q;
  assign o_tx_char     = char_q;
  assign o_grant_valid = gv_q;
  assign o_grant_id    = id_q;
  assign o_timeout     = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter.
// Expected values are hand-derived cycle by cycle.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [8*N-1:0] data;
  logic [N-1:0]  last;
  logic [N-1:0]  ack;
  logic          tx_start;
  logic [7:0]    tx_char;
  logic          busy;
  logic          done;
  logic          gv;
  logic [1:0]    gid;
  logic          tmo;

  int nchk = 0;
  int nerr = 0;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(16)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_data        (data),
    .i_last        (last),
    .o_ack         (ack),
    .o_tx_start    (tx_start),
    .o_tx_char     (tx_char),
    .i_tx_busy     (busy),
    .i_tx_done     (done),
    .o_grant_valid (gv),
    .o_grant_id    (gid),
    .o_timeout     (tmo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Frame of cyc cycles after start; done pulses on the last one.
  task automatic run_tx(input int cyc,
                        output int starts,
                        output int tmos);
    starts = 0;
    tmos   = 0;
    busy   = 1'b1;
    for (int i = 0; i < cyc - 1; i++) begin
      tick();
      if (tx_start) starts++;
      if (tmo) tmos++;
    end
    busy = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    int s, t;
    logic [7:0] b;
    rst  = 1'b1;
    req  = '0;
    data = '0;
    last = '0;
    busy = 1'b0;
    done = 1'b0;
    do_reset();

    chk("rst_gv",    32'(gv), 0);
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_ack",   32'(ack), 0);
    chk("rst_tmo",   32'(tmo), 0);
    chk("rst_char",  32'(tx_char), 0);
    chk("rst_id",    32'(gid), 0);

    // 1: three-byte message from requester 0
    req = 4'b0001;
    data[7:0] = 8'h41;
    last[0] = 1'b0;
    tick();
    chk("t1_gv", 32'(gv), 1);
    chk("t1_id", 32'(gid), 0);
    chk("t1_nostart", 32'(tx_start), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      b = 8'h41 + 8'(k);
      chk("t1_start", 32'(tx_start), 1);
      chk("t1_char", 32'(tx_char), 32'(b));
      chk("t1_ack", 32'(ack), 32'h1);
      if (k == 0) begin
        data[7:0] = 8'h42;
      end else if (k == 1) begin
        data[7:0] = 8'h43;
        last[0] = 1'b1;
      end else begin
        req = '0;
        last[0] = 1'b0;
      end
      run_tx(2400, s, t);
      chk("t1_extra_start", 32'(s), 0);
      chk("t1_gv_after", 32'(gv), (k == 2) ? 0 : 1);
    end
    tick();
    chk("t1_idle_start", 32'(tx_start), 0);

    // 2: all request, one-byte messages, order 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    last = 4'b1111;
    data = 32'h53525150;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_gv", 32'(gv), 1);
      chk("t2_id", 32'(gid), 32'(k % 4));
      tick();
      chk("t2_start", 32'(tx_start), 1);
      chk("t2_char", 32'(tx_char), 32'h50 + 32'(k % 4));
      chk("t2_ack", 32'(ack), 32'(1 << (k % 4)));
      run_tx(20, s, t);
      chk("t2_one_start", 32'(s), 0);
      chk("t2_release", 32'(gv), 0);
    end

    // 3: holder 1 mid-message keeps lock against req[2]
    req = 4'b0010;
    last = '0;
    data = '0;
    data[15:8] = 8'h61;
    tick();
    chk("t3_id1", 32'(gid), 1);
    tick();
    chk("t3_char61", 32'(tx_char), 32'h61);
    req = 4'b0110;
    data[15:8] = 8'h62;
    last[1] = 1'b1;
    data[23:16] = 8'h71;
    last[2] = 1'b1;
    run_tx(20, s, t);
    chk("t3_still1", 32'(gid), 1);
    chk("t3_still_gv", 32'(gv), 1);
    tick();
    chk("t3_start62", 32'(tx_start), 1);
    chk("t3_char62", 32'(tx_char), 32'h62);
    chk("t3_ack1", 32'(ack), 32'h2);
    req = 4'b0100;
    run_tx(20, s, t);
    chk("t3_gap", 32'(gv), 0);
    tick();
    chk("t3_gv2", 32'(gv), 1);
    chk("t3_id2", 32'(gid), 2);
    tick();
    chk("t3_char71", 32'(tx_char), 32'h71);
    chk("t3_ack2", 32'(ack), 32'h4);
    req = '0;
    run_tx(20, s, t);
    chk("t3_rel2", 32'(gv), 0);

    // 4: holder 3 drops req after first byte -> timeout
    req = 4'b1001;
    last = 4'b0001;
    data = '0;
    data[31:24] = 8'h81;
    data[7:0] = 8'h91;
    tick();
    chk("t4_id3", 32'(gid), 3);
    tick();
    chk("t4_char81", 32'(tx_char), 32'h81);
    chk("t4_ack3", 32'(ack), 32'h8);
    req = 4'b0001;
    run_tx(20, s, t);
    t = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (tmo) t++;
    end
    chk("t4_early_tmo", 32'(t), 0);
    chk("t4_held", 32'(gv), 1);
    tick();
    chk("t4_tmo", 32'(tmo), 1);
    chk("t4_rel", 32'(gv), 0);
    chk("t4_nostart", 32'(tx_start), 0);
    tick();
    chk("t4_tmo_pulse", 32'(tmo), 0);
    chk("t4_gv0", 32'(gv), 1);
    chk("t4_id0", 32'(gid), 0);
    tick();
    chk("t4_char91", 32'(tx_char), 32'h91);
    req = '0;
    run_tx(20, s, t);

    // 5: busy held 100 cycles in SEND
    req = 4'b0010;
    last = 4'b0010;
    data = '0;
    data[15:8] = 8'hA1;
    busy = 1'b1;
    tick();
    chk("t5_id1", 32'(gid), 1);
    s = 0;
    t = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_start) s++;
      if (tmo) t++;
    end
    chk("t5_no_start", 32'(s), 0);
    chk("t5_no_tmo", 32'(t), 0);
    busy = 1'b0;
    tick();
    chk("t5_start", 32'(tx_start), 1);
    chk("t5_charA1", 32'(tx_char), 32'hA1);
    chk("t5_ack1", 32'(ack), 32'h2);
    req = '0;
    run_tx(20, s, t);
    chk("t5_rel", 32'(gv), 0);

    // 6: reset one cycle after tx_start
    req = 4'b0100;
    last = '0;
    data = '0;
    data[23:16] = 8'hB1;
    data[7:0] = 8'hC1;
    tick();
    chk("t6_id2", 32'(gid), 2);
    tick();
    chk("t6_startB1", 32'(tx_start), 1);
    rst = 1'b1;
    busy = 1'b1;
    tick();
    rst = 1'b0;
    req = '0;
    chk("t6_gv", 32'(gv), 0);
    chk("t6_start", 32'(tx_start), 0);
    chk("t6_ack", 32'(ack), 0);
    chk("t6_char", 32'(tx_char), 0);
    chk("t6_tmo", 32'(tmo), 0);
    chk("t6_id", 32'(gid), 0);
    tick();
    tick();
    busy = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t6_late_gv", 32'(gv), 0);
    chk("t6_late_start", 32'(tx_start), 0);
    req = 4'b0101;
    last[0] = 1'b1;
    tick();
    chk("t6_gv_new", 32'(gv), 1);
    chk("t6_id0", 32'(gid), 0);
    tick();
    chk("t6_charC1", 32'(tx_char), 32'hC1);
    chk("t6_ack0", 32'(ack), 32'h1);
    req = '0;

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
